// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the multiplexed BCD display: active-low glyphs ({g,f,e,d,c,b,a})
// and default timing divisors.
package bcd_display_scan_pkg;

    localparam int SCAN_DIV_DEFAULT  = 50000;
    localparam int BLINK_DIV_DEFAULT = 256;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment glyph; non-BCD codes show a dash.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed display driver: snapshots an upstream BCD count, scans the
// digits, blanks leading zeros on request and blinks the whole display on overflow.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        ovr_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [15:0]   snap;
    logic          snap_ovr;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          blink_on;

    logic          scan_tick;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic [3:0]    lz;
    logic          blank_cur;
    logic          dark;

    assign scan_tick = (presc == PRESC_LAST);
    assign nibble    = snap[{idx, 2'b00} +: 4];

    // lz[k]: snapshot digits k..3 are all zero; digit 0 is never a leading zero.
    assign lz[3] = (snap[15:12] == 4'd0);
    assign lz[2] = lz[3] & (snap[11:8] == 4'd0);
    assign lz[1] = lz[2] & (snap[7:4] == 4'd0);
    assign lz[0] = 1'b0;

    assign blank_cur = blank_lz & lz[idx];
    assign dark      = snap_ovr & ~blink_on;

    bcd_to_seg7 u_dec (
        .bcd   (nibble),
        .seg_n (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap     <= '0;
            snap_ovr <= 1'b0;
            presc    <= '0;
            idx      <= 2'd0;
            bcnt     <= '0;
            blink_on <= 1'b1;
            an_n     <= 4'b1111;
            seg_n    <= SEG_OFF;
        end else begin
            if (load) begin
                snap     <= bcd_in;
                snap_ovr <= ovr_in;
            end

            if (scan_tick) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (!snap_ovr) begin
                bcnt     <= '0;
                blink_on <= 1'b1;
            end else if (scan_tick) begin
                if (bcnt == BLINK_LAST) begin
                    bcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end

            // Output register: reflects the index and snapshot as they stood before this edge.
            an_n  <= ~(4'b0001 << idx);
            seg_n <= (blank_cur || dark) ? SEG_OFF : glyph;
        end
    end

endmodule
